// File: rtl/meteor_mmio_pkg.sv
// Shared definitions for the cpu-side MMIO peripherals.
// Holds the default UART register addresses, status-word bit positions
// and the UART transmit FSM state encoding.
package meteor_mmio_pkg;

  localparam logic [31:0] UART_TX_ADDR_DEF   = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR_DEF = 32'h1000_0004;

  // Bit positions inside the status word returned on a status read.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational read port.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data   write request and data; ignored when full unless pop
//                   is accepted in the same cycle
//   pop, rd_data    read request; rd_data always shows the head entry
//   full, empty     occupancy flags from the current pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot this cycle, so a push into a full FIFO is legal then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter and end-of-run monitor.
// Sits beside the cpu data RAM and snoops its read/write port.
// Ports:
//   i_sys_clk, i_sys_rst          clock, synchronous active-high reset
//   i_ram_wr_*                    cpu write strobe/address/data
//   i_ram_rd_*                    cpu read strobe/address
//   o_mmio_wr_hit                 write targets an MMIO register (RAM write masked)
//   o_mmio_rd_hit, o_mmio_rd_data read targets the status word
//                                 {overflow, fifo_full, tx_busy} in bits [2:0]
//   i_end_flag, i_end_data        cpu end-of-program flag and exit code
//   o_uart_txd                    serial line, idle high
//   o_sim_done, o_sim_code        end seen and UART drained; latched exit code
module mmio_uart_tx
  import meteor_mmio_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_TX_ADDR   = ADDR_WIDTH'(UART_TX_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] UART_STAT_ADDR = ADDR_WIDTH'(UART_STAT_ADDR_DEF),
  parameter int                    CLK_DIV        = 16,
  parameter int                    FIFO_DEPTH     = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_ram_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_ram_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_wr_data,
  input  logic                  i_ram_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_ram_rd_addr,
  output logic                  o_mmio_wr_hit,
  output logic                  o_mmio_rd_hit,
  output logic [DATA_WIDTH-1:0] o_mmio_rd_data,
  input  logic                  i_end_flag,
  input  logic [DATA_WIDTH-1:0] i_end_data,
  output logic                  o_uart_txd,
  output logic                  o_sim_done,
  output logic [DATA_WIDTH-1:0] o_sim_code
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  tx_state_t             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  overflow_q, overflow_d;
  logic                  end_seen_q, end_seen_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] code_q, code_d;

  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_rd_data;
  logic                  tx_busy;
  logic                  baud_end;
  logic                  unused_wr_data;

  // Only the low byte of a TX write is transmitted.
  assign unused_wr_data = ^i_ram_wr_data[DATA_WIDTH-1:8];

  assign push          = i_ram_wr_en && (i_ram_wr_addr == UART_TX_ADDR);
  assign o_mmio_wr_hit = i_ram_wr_en &&
                         ((i_ram_wr_addr == UART_TX_ADDR) ||
                          (i_ram_wr_addr == UART_STAT_ADDR));
  assign o_mmio_rd_hit = i_ram_rd_en && (i_ram_rd_addr == UART_STAT_ADDR);
  assign tx_busy       = (state_q != IDLE) || !fifo_empty;
  assign baud_end      = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (i_sys_clk),
    .rst     (i_sys_rst),
    .push    (push),
    .wr_data (i_ram_wr_data[7:0]),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Status word assembled from current-cycle register state.
  always_comb begin
    o_mmio_rd_data                = {DATA_WIDTH{1'b0}};
    o_mmio_rd_data[STAT_BUSY_BIT] = tx_busy;
    o_mmio_rd_data[STAT_FULL_BIT] = fifo_full;
    o_mmio_rd_data[STAT_OVF_BIT]  = overflow_q;
  end

  // Transmit FSM next state: each state holds txd for CLK_DIV clocks.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = 3'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          state_d = START;
          txd_d   = 1'b0;
        end else begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // Shift out LSB first; the next bit is shift_q[1] before the shift lands.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back bytes have no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Overflow flag and end-of-run latch next state.
  always_comb begin
    overflow_d = overflow_q | (push & fifo_full & ~pop);
    end_seen_d = end_seen_q | i_end_flag;
    if (i_end_flag && !end_seen_q) begin
      code_d = i_end_data;
    end else begin
      code_d = code_q;
    end
    // Done waits until the last queued byte's stop bit has finished.
    done_d = done_q | (end_seen_q & fifo_empty & (state_q == IDLE));
  end

  // All control and output registers, synchronous reset.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
      end_seen_q <= 1'b0;
      done_q     <= 1'b0;
      code_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
      end_seen_q <= end_seen_d;
      done_q     <= done_d;
      code_q     <= code_d;
    end
  end

  assign o_uart_txd = txd_q;
  assign o_sim_done = done_q;
  assign o_sim_code = code_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: decode vector table plus
// directed sequences for framing, FIFO overflow, end/done and reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] TX_A   = 32'h1000_0000;
  localparam logic [31:0] STAT_A = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        wr_hit;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        end_flag;
  logic [31:0] end_data;
  logic        txd;
  logic        sim_done;
  logic [31:0] sim_code;

  int tests = 0;
  int fails = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .UART_TX_ADDR   (TX_A),
    .UART_STAT_ADDR (STAT_A),
    .CLK_DIV        (16),
    .FIFO_DEPTH     (8)
  ) dut (
    .i_sys_clk      (clk),
    .i_sys_rst      (rst),
    .i_ram_wr_en    (wr_en),
    .i_ram_wr_addr  (wr_addr),
    .i_ram_wr_data  (wr_data),
    .i_ram_rd_en    (rd_en),
    .i_ram_rd_addr  (rd_addr),
    .o_mmio_wr_hit  (wr_hit),
    .o_mmio_rd_hit  (rd_hit),
    .o_mmio_rd_data (rd_data),
    .i_end_flag     (end_flag),
    .i_end_data     (end_data),
    .o_uart_txd     (txd),
    .o_sim_done     (sim_done),
    .o_sim_code     (sim_code)
  );

  typedef struct {
    string       name;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        exp_wr_hit;
    logic        exp_rd_hit;
    logic [31:0] exp_rd_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic status(output logic [31:0] v);
    rd_en   = 1'b1;
    rd_addr = STAT_A;
    #1;
    v     = rd_data;
    rd_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("rx byte count", rx_q.size(), n);
  endtask

  // Serial receiver: samples mid-bit, 16 clocks per bit.
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (prev === 1'b1 && txd === 1'b0) begin
        repeat (8) @(posedge clk);
        #2;
        check("rx start bit", {31'd0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge clk);
          #2;
          b[i] = txd;
        end
        repeat (16) @(posedge clk);
        #2;
        check("rx stop bit", {31'd0, txd}, 32'd1);
        rx_q.push_back(b);
        prev = 1'b1;
      end else begin
        prev = txd;
      end
    end
  end

  initial begin
    logic [31:0] st;
    logic [7:0]  byte41;
    logic        exp_bit;
    int          early;
    int          lows;

    wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
    rd_en = 1'b0; rd_addr = 32'd0;
    end_flag = 1'b0; end_data = 32'd0;

    vecs[0] = '{"rd stat",       1'b0, 32'd0,          1'b1, STAT_A,         1'b0, 1'b1, 32'd0};
    vecs[1] = '{"rd other",      1'b0, 32'd0,          1'b1, 32'h2000_0000,  1'b0, 1'b0, 32'd0};
    vecs[2] = '{"rd txaddr",     1'b0, 32'd0,          1'b1, TX_A,           1'b0, 1'b0, 32'd0};
    vecs[3] = '{"rd stat no en", 1'b0, 32'd0,          1'b0, STAT_A,         1'b0, 1'b0, 32'd0};
    vecs[4] = '{"wr stat",       1'b1, STAT_A,         1'b0, 32'd0,          1'b1, 1'b0, 32'd0};
    vecs[5] = '{"wr +8",         1'b1, 32'h1000_0008,  1'b0, 32'd0,          1'b0, 1'b0, 32'd0};
    vecs[6] = '{"wr near miss",  1'b1, 32'h1000_0001,  1'b0, 32'd0,          1'b0, 1'b0, 32'd0};
    vecs[7] = '{"wr high alias", 1'b1, 32'h9000_0000,  1'b1, 32'h9000_0004,  1'b0, 1'b0, 32'd0};

    do_reset();

    // Reset state.
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset done", {31'd0, sim_done}, 32'd0);
    check("reset code", sim_code, 32'd0);
    status(st);
    check("reset status", st, 32'd0);

    // Decode table.
    for (int i = 0; i < 8; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_data = 32'hFF;
      rd_en   = vecs[i].rd_en;
      rd_addr = vecs[i].rd_addr;
      #1;
      check({vecs[i].name, " wr_hit"}, {31'd0, wr_hit}, {31'd0, vecs[i].exp_wr_hit});
      check({vecs[i].name, " rd_hit"}, {31'd0, rd_hit}, {31'd0, vecs[i].exp_rd_hit});
      check({vecs[i].name, " rd_data"}, rd_data, vecs[i].exp_rd_data);
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
    // Writes that missed TX (and the status write) must not have queued anything.
    tick();
    check("decode no tx", {31'd0, txd}, 32'd1);
    status(st);
    check("decode status idle", st, 32'd0);

    // Single byte 0x41, exact waveform.
    rx_q.delete();
    wr_en = 1'b1; wr_addr = TX_A; wr_data = 32'h0000_0041;
    #1;
    check("tx write hit", {31'd0, wr_hit}, 32'd1);
    tick();
    wr_en = 1'b0;
    check("tx41 idle before start", {31'd0, txd}, 32'd1);
    status(st);
    check("tx41 busy", st, 32'd1);
    tick();
    byte41 = 8'h41;
    for (int b = 0; b < 10; b++) begin
      if (b == 0) exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else exp_bit = byte41[b-1];
      for (int c = 0; c < 16; c++) begin
        check($sformatf("tx41 bit%0d clk%0d", b, c), {31'd0, txd}, {31'd0, exp_bit});
        tick();
      end
    end
    check("tx41 idle after", {31'd0, txd}, 32'd1);
    status(st);
    check("tx41 status after", st, 32'd0);
    wait_rx(1, 50);
    if (rx_q.size() > 0) check("tx41 rx byte", {24'd0, rx_q[0]}, 32'h41);

    // Ten consecutive writes: the FIFO fills and the tenth is dropped.
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = TX_A; wr_data = 32'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    status(st);
    check("burst status", st, 32'h7);
    wait_rx(9, 2000);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check($sformatf("burst byte%0d", i), {24'd0, rx_q[i]}, 32'(i + 1));
    end
    repeat (200) tick();
    check("burst 10th dropped", rx_q.size(), 9);
    status(st);
    check("burst status drained", st, 32'h4);

    // End with empty FIFO, then a second end flag.
    do_reset();
    rx_q.delete();
    end_flag = 1'b1; end_data = 32'h1;
    tick();
    end_flag = 1'b0; end_data = 32'h0;
    check("end1 code", sim_code, 32'h1);
    check("end1 done not yet", {31'd0, sim_done}, 32'd0);
    tick();
    check("end1 done", {31'd0, sim_done}, 32'd1);
    end_flag = 1'b1; end_data = 32'h5;
    tick();
    end_flag = 1'b0;
    tick();
    check("end2 code kept", sim_code, 32'h1);
    // Pushes after end are still sent; done stays sticky.
    wr_en = 1'b1; wr_addr = TX_A; wr_data = 32'h5A;
    tick();
    wr_en = 1'b0;
    wait_rx(1, 400);
    if (rx_q.size() > 0) check("post-end byte", {24'd0, rx_q[0]}, 32'h5A);
    check("done sticky", {31'd0, sim_done}, 32'd1);

    // Three bytes queued, end flag next cycle: done only after last stop bit.
    do_reset();
    rx_q.delete();
    wr_en = 1'b1; wr_addr = TX_A; wr_data = 32'h11; tick();
    wr_data = 32'h22; tick();
    wr_data = 32'h33; tick();
    wr_en = 1'b0; end_flag = 1'b1; end_data = 32'h0;
    tick();
    end_flag = 1'b0;
    // Now in cycle 4; byte 3's stop bit ends at cycle 481.
    check("end3 code", sim_code, 32'h0);
    early = 0;
    for (int cyc = 4; cyc < 482; cyc++) begin
      if (sim_done !== 1'b0) early++;
      tick();
    end
    check("end3 done early cycles", early, 0);
    check("end3 done at idle", {31'd0, sim_done}, 32'd0);
    check("end3 txd idle", {31'd0, txd}, 32'd1);
    tick();
    check("end3 done", {31'd0, sim_done}, 32'd1);
    check("end3 rx count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("end3 byte0", {24'd0, rx_q[0]}, 32'h11);
      check("end3 byte1", {24'd0, rx_q[1]}, 32'h22);
      check("end3 byte2", {24'd0, rx_q[2]}, 32'h33);
    end

    // Reset during DATA bit 3 with two bytes still queued.
    do_reset();
    wr_en = 1'b1; wr_addr = TX_A; wr_data = 32'hA5; tick();
    wr_data = 32'h3C; tick();
    wr_data = 32'h77; tick();
    wr_en = 1'b0; end_flag = 1'b1; end_data = 32'h9;
    tick();
    end_flag = 1'b0;
    for (int cyc = 4; cyc < 70; cyc++) tick();
    check("rst mid bit3 low", {31'd0, txd}, 32'd0);
    check("rst pre code", sim_code, 32'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst txd high", {31'd0, txd}, 32'd1);
    status(st);
    check("rst status", st, 32'd0);
    check("rst code", sim_code, 32'd0);
    check("rst done", {31'd0, sim_done}, 32'd0);
    lows = 0;
    for (int c = 0; c < 400; c++) begin
      if (txd !== 1'b1) lows++;
      tick();
    end
    check("rst nothing sent", lows, 0);
    rx_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
